// File: rtl/wave_capture_ctrl.sv
// wave_capture_ctrl: fills the display line buffer with one frame's
// worth of waveform samples, optionally aligned to a rising crossing.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   frame_tick         start-of-vblank pulse (ignored if busy or freeze)
//   wave_sel, stride   source select and address step (0 acts as 1)
//   trig_en            search for a rising MID crossing before capture
//   freeze             hold the current trace (ignore frame_tick)
//   sine/square/triangle  ROM data, valid 1 cycle after rom_rd
//   rom_addr, rom_rd   shared ROM read port (registered)
//   buf_we/waddr/wdata line-buffer write port
//   busy, done         capture in progress / one-cycle completion pulse
//   trig_timeout       sticky: last search gave up without a crossing
module wave_capture_ctrl #(
    parameter int              NSAMP        = 240,
    parameter int              AW           = 16,
    parameter int              DW           = 12,
    parameter int              ROM_DEPTH    = 65536,
    parameter logic [DW-1:0]   MID          = 12'h800,
    parameter int              TRIG_TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_tick,
    input  logic [1:0]    wave_sel,
    input  logic [3:0]    stride,
    input  logic          trig_en,
    input  logic          freeze,
    input  logic [DW-1:0] sine,
    input  logic [DW-1:0] square,
    input  logic [DW-1:0] triangle,
    output logic [AW-1:0] rom_addr,
    output logic          rom_rd,
    output logic          buf_we,
    output logic [7:0]    buf_waddr,
    output logic [DW-1:0] buf_wdata,
    output logic          busy,
    output logic          done,
    output logic          trig_timeout
);

    localparam int              SCW   = $clog2(TRIG_TIMEOUT);
    localparam logic [SCW-1:0]  SLAST = SCW'(TRIG_TIMEOUT - 1);
    localparam logic [7:0]      LAST  = 8'(NSAMP - 1);
    localparam logic [AW:0]     DEPTH = (AW+1)'(ROM_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        CAPTURE,
        DRAIN,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  ptr_q, ptr_d;
    logic [AW-1:0]  addr_d;
    logic           rd_d;
    logic           rd_d1_q;
    logic [AW-1:0]  a_d1_q;
    logic [1:0]     sel_q, sel_d;
    logic [3:0]     stride_q, stride_d;
    logic [DW-1:0]  prev_q, prev_d;
    logic           have_prev_q, have_prev_d;
    logic [SCW-1:0] srch_q, srch_d;
    logic [7:0]     iss_q, iss_d;
    logic [7:0]     widx_q, widx_d;
    logic           discard_q, discard_d;
    logic           we_d;
    logic [7:0]     waddr_d;
    logic [DW-1:0]  wdata_d;
    logic           busy_d, done_d, tto_d;

    logic [DW-1:0]  cur;
    logic           crossing;
    logic [3:0]     st_new;
    logic [AW-1:0]  stride_w, stride2_w;

    // Addresses wrap modulo the ROM depth; inc is always below DEPTH.
    function automatic logic [AW-1:0] wrap_add(
        input logic [AW-1:0] a,
        input logic [AW-1:0] inc
    );
        logic [AW:0] sum;
        sum = {1'b0, a} + {1'b0, inc};
        if (sum >= DEPTH) begin
            return AW'(sum - DEPTH);
        end
        return sum[AW-1:0];
    endfunction

    always_comb begin
        cur = '0;
        unique case (sel_q)
            2'b00:   cur = square;
            2'b01:   cur = sine;
            2'b11:   cur = triangle;
            default: cur = '0;
        endcase
    end

    assign crossing  = have_prev_q && (prev_q < MID) && (cur >= MID);
    assign st_new    = (stride == 4'd0) ? 4'd1 : stride;
    assign stride_w  = AW'(stride_q);
    assign stride2_w = AW'({stride_q, 1'b0});

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        addr_d      = rom_addr;
        rd_d        = 1'b0;
        sel_d       = sel_q;
        stride_d    = stride_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        srch_d      = srch_q;
        iss_d       = iss_q;
        widx_d      = widx_q;
        discard_d   = discard_q;
        we_d        = 1'b0;
        waddr_d     = buf_waddr;
        wdata_d     = buf_wdata;
        busy_d      = busy;
        done_d      = 1'b0;
        tto_d       = trig_timeout;

        unique case (state_q)
            IDLE: begin
                if (frame_tick && !freeze) begin
                    sel_d       = wave_sel;
                    stride_d    = st_new;
                    busy_d      = 1'b1;
                    tto_d       = 1'b0;
                    have_prev_d = 1'b0;
                    srch_d      = '0;
                    widx_d      = '0;
                    discard_d   = 1'b0;
                    // First read goes out on the accepting edge.
                    rd_d        = 1'b1;
                    addr_d      = ptr_q;
                    if (trig_en) begin
                        state_d = SEARCH;
                        ptr_d   = wrap_add(ptr_q, AW'(1));
                        iss_d   = '0;
                    end else begin
                        state_d = CAPTURE;
                        ptr_d   = wrap_add(ptr_q, AW'(st_new));
                        iss_d   = 8'd1;
                    end
                end
            end

            SEARCH: begin
                rd_d   = 1'b1;
                addr_d = ptr_q;
                ptr_d  = wrap_add(ptr_q, AW'(1));
                if (rd_d1_q) begin
                    prev_d      = cur;
                    have_prev_d = 1'b1;
                    srch_d      = srch_q + 1'b1;
                    if (crossing) begin
                        // Crossing sample is buf[0]; the read
                        // behind it is in flight and is dropped.
                        we_d      = 1'b1;
                        waddr_d   = '0;
                        wdata_d   = cur;
                        widx_d    = 8'd1;
                        discard_d = 1'b1;
                        addr_d    = wrap_add(a_d1_q, stride_w);
                        ptr_d     = wrap_add(a_d1_q, stride2_w);
                        iss_d     = 8'd2;
                        state_d   = CAPTURE;
                    end else if (srch_q == SLAST) begin
                        // Give up: the in-flight read becomes
                        // index 0 and capture continues after it.
                        tto_d   = 1'b1;
                        widx_d  = '0;
                        addr_d  = wrap_add(rom_addr, stride_w);
                        ptr_d   = wrap_add(rom_addr, stride2_w);
                        iss_d   = 8'd2;
                        state_d = CAPTURE;
                    end
                end
            end

            CAPTURE, DRAIN: begin
                if (state_q == CAPTURE) begin
                    rd_d   = 1'b1;
                    addr_d = ptr_q;
                    ptr_d  = wrap_add(ptr_q, stride_w);
                    iss_d  = iss_q + 1'b1;
                    if (iss_q == LAST) begin
                        state_d = DRAIN;
                    end
                end
                if (rd_d1_q) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                    end else begin
                        we_d    = 1'b1;
                        waddr_d = widx_q;
                        wdata_d = cur;
                        widx_d  = widx_q + 1'b1;
                        if (state_q == DRAIN && widx_q == LAST) begin
                            state_d = DONE;
                        end
                    end
                end
            end

            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            rom_addr     <= '0;
            rom_rd       <= 1'b0;
            rd_d1_q      <= 1'b0;
            a_d1_q       <= '0;
            sel_q        <= '0;
            stride_q     <= 4'd1;
            prev_q       <= '0;
            have_prev_q  <= 1'b0;
            srch_q       <= '0;
            iss_q        <= '0;
            widx_q       <= '0;
            discard_q    <= 1'b0;
            buf_we       <= 1'b0;
            buf_waddr    <= '0;
            buf_wdata    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            trig_timeout <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            rom_addr     <= addr_d;
            rom_rd       <= rd_d;
            rd_d1_q      <= rom_rd;
            a_d1_q       <= rom_addr;
            sel_q        <= sel_d;
            stride_q     <= stride_d;
            prev_q       <= prev_d;
            have_prev_q  <= have_prev_d;
            srch_q       <= srch_d;
            iss_q        <= iss_d;
            widx_q       <= widx_d;
            discard_q    <= discard_d;
            buf_we       <= we_d;
            buf_waddr    <= waddr_d;
            buf_wdata    <= wdata_d;
            busy         <= busy_d;
            done         <= done_d;
            trig_timeout <= tto_d;
        end
    end

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// tb_wave_capture_ctrl: directed bench with ROM models and a
// read/write scoreboard for wave_capture_ctrl.
module tb_wave_capture_ctrl;

    localparam logic [11:0] MIDV = 12'h800;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic [1:0]  wave_sel = 2'b01;
    logic [3:0]  stride = 4'd1;
    logic        trig_en = 1'b0;
    logic        freeze = 1'b0;
    logic [11:0] sine, square, triangle;
    logic [15:0] rom_addr;
    logic        rom_rd, buf_we, busy, done, trig_timeout;
    logic [7:0]  buf_waddr;
    logic [11:0] buf_wdata;

    int checks = 0;
    int errors = 0;
    int n_rd = 0;
    int n_wr = 0;
    int n_done = 0;

    logic [15:0] exp_addr_q[$];
    logic [19:0] exp_wr_q[$];
    logic [15:0] exp_ptr = 16'd0;
    logic [15:0] rom_q = 16'd0;
    logic [15:0] tri_cross = 16'd100;
    logic [11:0] sq_val = 12'h900;

    always #5 clk = ~clk;

    wave_capture_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .wave_sel     (wave_sel),
        .stride       (stride),
        .trig_en      (trig_en),
        .freeze       (freeze),
        .sine         (sine),
        .square       (square),
        .triangle     (triangle),
        .rom_addr     (rom_addr),
        .rom_rd       (rom_rd),
        .buf_we       (buf_we),
        .buf_waddr    (buf_waddr),
        .buf_wdata    (buf_wdata),
        .busy         (busy),
        .done         (done),
        .trig_timeout (trig_timeout)
    );

    function automatic logic [11:0] src(input logic [1:0] s,
                                        input logic [15:0] a);
        logic [15:0] off;
        off = a - tri_cross;
        case (s)
            2'b00:   return sq_val;
            2'b01:   return a[11:0];
            2'b11:   return (a < tri_cross) ? 12'h7FF
                                            : 12'h800 + off[11:0];
            default: return 12'h000;
        endcase
    endfunction

    // Synchronous ROMs: data for a read appears the cycle after rom_rd.
    always @(posedge clk) if (rom_rd) rom_q <= rom_addr;
    assign sine     = src(2'b01, rom_q);
    assign square   = src(2'b00, rom_q);
    assign triangle = src(2'b11, rom_q);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon_rd
        logic [15:0] ea;
        if (rst_n && rom_rd) begin
            n_rd++;
            chk("rd_expected", 32'(exp_addr_q.size() != 0), 32'd1);
            if (exp_addr_q.size() != 0) begin
                ea = exp_addr_q.pop_front();
                chk("rom_addr", 32'(rom_addr), 32'(ea));
            end
        end
    end

    always @(negedge clk) begin : mon_wr
        logic [19:0] ew;
        if (rst_n && buf_we) begin
            n_wr++;
            chk("wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
            if (exp_wr_q.size() != 0) begin
                ew = exp_wr_q.pop_front();
                chk("buf_waddr", 32'(buf_waddr), 32'(ew[19:12]));
                chk("buf_wdata", 32'(buf_wdata), 32'(ew[11:0]));
            end
        end
        if (done) n_done++;
    end

    // Reference model: push the reads and writes one capture should make.
    task automatic build_exp(input logic [1:0] sel, input logic [3:0] st,
                             input logic trig, output logic tto);
        int s;
        int found;
        logic [15:0] base;
        s = (st == 4'd0) ? 1 : int'(st);
        found = -1;
        base = exp_ptr;
        tto = 1'b0;
        if (trig) begin
            for (int i = 1; i < 1024 && found < 0; i++) begin
                if (src(sel, exp_ptr + 16'(i - 1)) < MIDV &&
                    src(sel, exp_ptr + 16'(i)) >= MIDV)
                    found = i;
            end
            if (found >= 0) begin
                for (int i = 0; i <= found + 1; i++)
                    exp_addr_q.push_back(exp_ptr + 16'(i));
                base = exp_ptr + 16'(found);
            end else begin
                for (int i = 0; i <= 1024; i++)
                    exp_addr_q.push_back(exp_ptr + 16'(i));
                base = exp_ptr + 16'd1024;
                tto = 1'b1;
            end
        end else begin
            exp_addr_q.push_back(base);
        end
        for (int k = 1; k < 240; k++)
            exp_addr_q.push_back(base + 16'(k * s));
        for (int k = 0; k < 240; k++)
            exp_wr_q.push_back({8'(k), src(sel, base + 16'(k * s))});
        exp_ptr = base + 16'(240 * s);
    endtask

    task automatic run_capture(input logic [1:0] sel, input logic [3:0] st,
                               input logic trig, input bit disturb,
                               input bit chk_lat);
        logic tto;
        int lat;
        build_exp(sel, st, trig, tto);
        @(negedge clk);
        wave_sel = sel;
        stride = st;
        trig_en = trig;
        frame_tick = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            frame_tick = disturb && (lat == 50);
            if (disturb && lat == 50) begin
                wave_sel = ~sel;
                stride = 4'd7;
                trig_en = ~trig;
            end
            if (lat == 1) begin
                chk("busy_start", 32'(busy), 32'd1);
                chk("tto_cleared", 32'(trig_timeout), 32'd0);
            end
        end while (!done && lat < 3000);
        chk("done_seen", 32'(done), 32'd1);
        if (chk_lat) chk("done_latency", 32'(lat), 32'd243);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("trig_timeout", 32'(trig_timeout), 32'(tto));
        chk("rd_left", 32'(exp_addr_q.size()), 32'd0);
        chk("wr_left", 32'(exp_wr_q.size()), 32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin : stim
        int rd0, wr0, d0, n;
        logic tto_e;

        repeat (3) @(negedge clk);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_rom_rd", 32'(rom_rd), 32'd0);
        chk("rst_buf_we", 32'(buf_we), 32'd0);
        chk("rst_buf_waddr", 32'(buf_waddr), 32'd0);
        chk("rst_buf_wdata", 32'(buf_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tto", 32'(trig_timeout), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Free-running sine, stride 1, from address 0.
        run_capture(2'b01, 4'd1, 1'b0, 1'b0, 1'b1);

        // Frozen: frame_tick must do nothing.
        rd0 = n_rd;
        wr0 = n_wr;
        freeze = 1'b1;
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        repeat (20) @(negedge clk);
        chk("freeze_reads", 32'(n_rd), 32'(rd0));
        chk("freeze_writes", 32'(n_wr), 32'(wr0));
        chk("freeze_busy", 32'(busy), 32'd0);
        freeze = 1'b0;

        // Constant source, stride 0, inputs and ticks disturbed mid-run.
        run_capture(2'b10, 4'd0, 1'b0, 1'b1, 1'b1);

        // Reset in the middle of a capture.
        build_exp(2'b01, 4'd1, 1'b0, tto_e);
        @(negedge clk);
        wave_sel = 2'b01;
        stride = 4'd1;
        trig_en = 1'b0;
        frame_tick = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            frame_tick = 1'b0;
            n++;
        end while (!(buf_we && buf_waddr == 8'd120) && n < 1000);
        chk("reach_idx120", 32'(n < 1000), 32'd1);
        d0 = n_done;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rom_addr", 32'(rom_addr), 32'd0);
        chk("arst_rom_rd", 32'(rom_rd), 32'd0);
        chk("arst_buf_we", 32'(buf_we), 32'd0);
        chk("arst_buf_waddr", 32'(buf_waddr), 32'd0);
        chk("arst_buf_wdata", 32'(buf_wdata), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        chk("arst_no_done", 32'(n_done), 32'(d0));
        exp_addr_q.delete();
        exp_wr_q.delete();
        exp_ptr = 16'd0;
        rst_n = 1'b1;
        @(negedge clk);

        // Triggered triangle: crossing at address 100.
        tri_cross = 16'd100;
        run_capture(2'b11, 4'd1, 1'b1, 1'b0, 1'b0);

        // Walk the pointer up near the top of the address space.
        for (int i = 0; i < 18; i++)
            run_capture(2'b10, 4'd15, 1'b0, 1'b0, 1'b0);
        tri_cross = 16'd65290;
        run_capture(2'b11, 4'd1, 1'b1, 1'b0, 1'b0);

        // Stride 3 from 65530 wraps 65533 -> 0 -> 3.
        run_capture(2'b01, 4'd3, 1'b0, 1'b0, 1'b1);

        // No crossing on constant 0x900: search times out.
        sq_val = 12'h900;
        run_capture(2'b00, 4'd2, 1'b1, 1'b0, 1'b0);

        // Frozen tick keeps the flag; an accepted tick clears it.
        rd0 = n_rd;
        freeze = 1'b1;
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        repeat (5) @(negedge clk);
        chk("tto_held", 32'(trig_timeout), 32'd1);
        chk("freeze2_reads", 32'(n_rd), 32'(rd0));
        freeze = 1'b0;
        run_capture(2'b01, 4'd1, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_capture_ctrl.md
Name: wave_capture_ctrl

Overview:
- Sequences waveform sample reads into the 240-entry display line buffer once per video frame.
- Starts each capture during vertical blanking, gated by the freeze input.
- Selects the source (square, sine or triangle), applies a decimation stride, and can align the capture to a rising mid-scale crossing so the trace is stable frame to frame.
- Sits between the three waveform sample ROMs and the VGA pixel path, which reads the buffer during active video.

Parameters:
- NSAMP, 240, samples captured per frame (buffer depth used).
- AW, 16, sample ROM address width.
- DW, 12, sample width.
- ROM_DEPTH, 65536, ROM entries; addresses wrap modulo ROM_DEPTH.
- MID, 12'h800, trigger threshold.
- TRIG_TIMEOUT, 1024, maximum search reads before a forced start.

Ports:
- clk  in  1  system clock (same domain as the VGA pixel clock consumer).
- rst_n  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse at the start of vertical blanking.
- wave_sel  in  2  source select: 00 square, 01 sine, 11 triangle, 10 constant 12'h000.
- stride  in  4  address step per captured sample; 0 is treated as 1.
- trig_en  in  1  1 = search for a rising crossing before capture.
- freeze  in  1  1 = ignore frame_tick (hold the displayed trace).
- sine  in  DW  sine ROM data.
- square  in  DW  square ROM data.
- triangle  in  DW  triangle ROM data.
- rom_addr  out  AW  shared ROM read address (registered).
- rom_rd  out  1  read strobe; data valid on the ROM inputs exactly 1 cycle later.
- buf_we  out  1  line-buffer write enable.
- buf_waddr  out  8  line-buffer write index, 0..NSAMP-1.
- buf_wdata  out  DW  line-buffer write data.
- busy  out  1  high from accepted frame_tick until done.
- done  out  1  one-cycle pulse after the last buffer write.
- trig_timeout  out  1  sticky: the last search hit TRIG_TIMEOUT; cleared at the next accepted frame_tick.

Behaviour:
- Reset (async, any state): state IDLE; rom_addr=0, rom_rd=0, buf_we=0, buf_waddr=0, buf_wdata=0, busy=0, done=0, trig_timeout=0; read pointer=0.
- Reset mid-capture aborts immediately. The buffer keeps partial contents; no done pulse is issued.
- States: IDLE, SEARCH, CAPTURE, DRAIN, DONE.
- IDLE:
  - frame_tick=1 and freeze=0 → latch wave_sel and stride (max(stride,1)); busy=1; clear trig_timeout.
  - Next state is SEARCH if trig_en=1, else CAPTURE.
  - frame_tick while busy or with freeze=1 is ignored.
- Mux: the selected source is sampled 1 cycle after each rom_rd, using the latched select.
- SEARCH:
  - Issues rom_rd every cycle at consecutive addresses (step 1) from the read pointer.
  - Keeps the previous returned sample.
  - Crossing = prev < MID and cur >= MID, unsigned. The first returned sample has no prev, so it cannot trigger.
  - On crossing at address A: that sample is written as buf[0] on the next cycle, the in-flight read (A+1) is discarded, and the state moves to CAPTURE with next address A+stride.
  - After TRIG_TIMEOUT returned samples with no crossing: set trig_timeout and enter CAPTURE from the current pointer with index 0 (no discard).
- CAPTURE:
  - One rom_rd per cycle; address advances by the latched stride, modulo ROM_DEPTH.
  - Each returned sample is written 1 cycle after its rom_rd (buf_we=1, buf_waddr incrementing from the next free index).
  - After the read for index NSAMP-1 is issued, rom_rd drops and the state moves to DRAIN.
- DRAIN: writes the final sample (index NSAMP-1), then goes to DONE.
- DONE:
  - done=1 for 1 cycle, busy=0, return to IDLE.
  - Read pointer = the address after the last read, so free-running (trig_en=0) captures continue through the waveform.
- Throughput: exactly NSAMP writes per capture, no gaps. Untriggered latency from frame_tick to done = NSAMP+3 cycles.
- Address arithmetic is AW bits, wrapping. buf_waddr never exceeds NSAMP-1.
- Inputs wave_sel, stride and trig_en changing mid-capture have no effect until the next accepted frame_tick.

Test Plan:
- Reset released, trig_en=0, stride=1, wave_sel=01, sine ROM data = address LSBs, one frame_tick →
  - rom_addr 0..239 on consecutive cycles;
  - buf writes 0..239 with data 0..239;
  - done at cycle 243; trig_timeout=0.
- stride=0 then stride=3, read pointer at 65530 → addresses advance by 1 for stride=0, and by 3 wrapping 65533→0→3 for stride=3.
- trig_en=1, triangle ROM rising through 12'h800 at address 100 (12'h7FF at 99, 12'h800 at 100) → buf[0]=12'h800; next captured addresses 101,102…; address 101's first read is discarded.
- trig_en=1, constant data 12'h900 → trig_timeout=1 after 1024 search reads; 240 writes follow; flag cleared at the next accepted frame_tick.
- freeze=1 with frame_tick → no reads or writes. A second frame_tick during busy is ignored. wave_sel=10 → all writes 12'h000.
- rst_n asserted at capture index 120 → all outputs reset asynchronously, no done pulse; the next frame_tick restarts at address 0.
